strobe_decimator: RTL and testbench
===================================

Name: strobe_decimator

Overview:
- Symbol-rate decimator at the receive end of the ZCTED timing-recovery loop.
- Takes the 2-samples/symbol interpolator output and the NCO underflow strobe.
- On each strobe it forms an {on-time, midpoint} sample pair, buffers it in a small FIFO, and delivers it to the symbol-rate consumers (slicer, ZCTED error computation) over a valid/ready handshake.
- It is the rate-reducing counterpart of the zero-stuffing upsampler that returns the error to sample rate.

Parameters:
DATA_WIDTH, 16, width of signed samples in and out
DEPTH, 4, FIFO entries; power of two, minimum 2
CNT_WIDTH, 8, width of the saturating drop counter

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
x_in  input  DATA_WIDTH  signed interpolated sample, 2 samples/symbol
x_valid  input  1  x_in is valid this cycle
underflow  input  1  NCO strobe; marks x_in as the on-time sample; only meaningful when x_valid=1
clr  input  1  synchronous flush of FIFO, history and status
sym_out  output  DATA_WIDTH  signed on-time sample of the head pair
mid_out  output  DATA_WIDTH  signed midpoint sample (previous valid x_in) of the head pair
out_valid  output  1  head pair valid
out_ready  input  1  consumer accepts the head pair
level  output  clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
overflow  output  1  sticky; set when a pair was dropped
drop_cnt  output  CNT_WIDTH  count of dropped pairs, saturates at all-ones

Behaviour:
- Reset (rst=1) has priority over everything. Reset values:
  - sym_out=0, mid_out=0, out_valid=0, level=0, overflow=0, drop_cnt=0
  - history register prev_sample=0
  - FIFO pointers=0
- clr=1 (rst=0) has the same effect as reset on all state for that cycle. Pushes and pops in a clr cycle are discarded.
- History:
  - On every cycle with x_valid=1, prev_sample <= x_in, whether or not underflow is high.
  - Cycles with x_valid=0 leave prev_sample unchanged.
- Push condition: x_valid=1 and underflow=1. The pushed pair is {sym=x_in, mid=prev_sample}, where prev_sample is the value before this cycle's update.
- underflow=1 with x_valid=0 is ignored: no push, no counter change.
- Back-to-back strobes on consecutive valid samples push two pairs. The second pair's mid equals the first pair's sym. This is legal and is not flagged.
- Pop condition: out_valid=1 and out_ready=1.
- FIFO storage is circular:
  - rd/wr pointers are clog2(DEPTH) bits and wrap modulo DEPTH.
  - level is updated +1 on push only, -1 on pop only, unchanged on both or neither.
- Full handling:
  - If level=DEPTH and a push occurs without a same-cycle pop, the pair is dropped. overflow <= 1, and drop_cnt increments, saturating.
  - Push while full with a same-cycle pop is accepted, with no drop.
  - Push while empty is always accepted.
- Output:
  - out_valid = (level != 0).
  - sym_out/mid_out present the head entry, which is registered storage with no combinational path from x_in.
  - Latency from push to out_valid=1 is 1 cycle when the FIFO is empty.
  - While out_valid=1 and out_ready=0, sym_out/mid_out/out_valid are held stable.
  - When out_valid=0, sym_out/mid_out hold their last value (0 after reset/clr).
- Width and arithmetic: samples pass through unmodified, with no scaling or sign extension. drop_cnt stops at 2^CNT_WIDTH-1.
- No internal state machine beyond the FIFO and history. Everything is single clock domain.

Test Plan:
1. Reset mid-stream:
   - Stimulus: fill 3 pairs, assert rst for 1 cycle.
   - Response: next cycle out_valid=0, level=0, overflow=0, drop_cnt=0, sym_out=0, mid_out=0. The first strobe after reset yields mid_out=0.
2. Basic decimation:
   - Stimulus: x_valid=1 continuously, x_in=10,20,30,40,50, underflow high with 30 and 50, out_ready=1.
   - Response: pairs (sym=30, mid=20) then (sym=50, mid=40). Each appears 1 cycle after its strobe. level returns to 0.
3. Gaps and ignored strobes:
   - Stimulus: x_in=5 valid, idle cycle with underflow=1 and x_valid=0, then x_in=7 valid with underflow=1.
   - Response: exactly one pair (sym=7, mid=5). No drop.
4. Backpressure and overflow:
   - Stimulus: DEPTH=4, out_ready=0, 6 strobed samples 1..6.
   - Response: level=4, overflow=1, drop_cnt=2. After out_ready=1 the consumer receives sym=1,2,3,4 in order with data stable while stalled.
5. Full with simultaneous push/pop:
   - Stimulus: level=4, out_ready=1 and a strobe in the same cycle.
   - Response: level stays 4, drop_cnt unchanged, the new pair is delivered in order.
6. Saturation and clr:
   - Stimulus: CNT_WIDTH=2, force 5 drops, then pulse clr.
   - Response: drop_cnt reads 3 (saturated) before clr. After clr: drop_cnt=0, overflow=0, level=0, and the next pair has mid=0.

Source files
------------

// File: rtl/strobe_decimator.sv
// strobe_decimator
//   Symbol-rate decimator for the receive end of the ZCTED timing-recovery loop.
//   Each NCO underflow strobe on a valid interpolated sample forms an
//   {on-time, midpoint} pair. The midpoint is the previous valid sample. The
//   pair is buffered in a small circular FIFO and handed to the symbol-rate
//   consumers.
//
//   Handshake: a pair transfers on every rising edge where out_valid=1 and
//   out_ready=1. out_valid never depends combinationally on out_ready. While
//   out_valid=1 and out_ready=0, out_valid, sym_out and mid_out stay stable.
//
//   Ports:
//     clk, rst    - clock; synchronous active-high reset
//     x_in        - signed interpolated sample (2 samples/symbol)
//     x_valid     - x_in valid this cycle
//     underflow   - NCO strobe: x_in is the on-time sample (needs x_valid)
//     clr         - synchronous flush of FIFO, history and status
//     sym_out     - on-time sample of the head pair (registered)
//     mid_out     - midpoint sample of the head pair (registered)
//     out_valid   - head pair valid
//     out_ready   - consumer accepts the head pair
//     level       - FIFO occupancy, 0..DEPTH
//     overflow    - sticky: a pair was dropped because the FIFO was full
//     drop_cnt    - saturating count of dropped pairs
module strobe_decimator #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 8,
    localparam int AW        = $clog2(DEPTH),
    localparam int LW        = AW + 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic signed [DATA_WIDTH-1:0] x_in,
    input  logic                         x_valid,
    input  logic                         underflow,
    input  logic                         clr,
    output logic signed [DATA_WIDTH-1:0] sym_out,
    output logic signed [DATA_WIDTH-1:0] mid_out,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [LW-1:0]                level,
    output logic                         overflow,
    output logic [CNT_WIDTH-1:0]         drop_cnt
);

    logic signed [DATA_WIDTH-1:0] sym_mem [DEPTH];
    logic signed [DATA_WIDTH-1:0] mid_mem [DEPTH];

    logic signed [DATA_WIDTH-1:0] prev_q;
    logic signed [DATA_WIDTH-1:0] sym_q, sym_d;
    logic signed [DATA_WIDTH-1:0] mid_q, mid_d;
    logic [AW-1:0]                rd_q, rd_d;
    logic [AW-1:0]                wr_q, wr_d;
    logic [LW-1:0]                level_q, level_d;
    logic                         ovf_q, ovf_d;
    logic [CNT_WIDTH-1:0]         drop_q, drop_d;

    logic                         push_req;
    logic                         pop;
    logic                         full;
    logic                         push_ok;
    logic                         drop;
    logic [AW-1:0]                rd_next;

    assign out_valid = (level_q != '0);
    assign level     = level_q;
    assign overflow  = ovf_q;
    assign drop_cnt  = drop_q;
    assign sym_out   = sym_q;
    assign mid_out   = mid_q;

    always_comb begin
        push_req = x_valid & underflow;
        pop      = out_valid & out_ready;
        full     = (level_q == LW'(DEPTH));
        // A full FIFO still accepts a push when the head leaves in the same cycle.
        push_ok  = push_req & (~full | pop);
        drop     = push_req & full & ~pop;
        rd_next  = rd_q + AW'(1);

        rd_d    = pop ? rd_next : rd_q;
        wr_d    = push_ok ? (wr_q + AW'(1)) : wr_q;
        level_d = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + LW'(1);
        end else if (pop && !push_ok) begin
            level_d = level_q - LW'(1);
        end

        ovf_d  = ovf_q | drop;
        drop_d = drop_q;
        if (drop && (drop_q != '1)) begin
            drop_d = drop_q + CNT_WIDTH'(1);
        end

        // The output register always mirrors the next head entry. When the
        // FIFO empties, it keeps the last delivered pair.
        sym_d = sym_q;
        mid_d = mid_q;
        if (level_d != '0) begin
            if ((level_q == '0) || (pop && (level_q == LW'(1)))) begin
                // The incoming pair becomes the head directly.
                sym_d = x_in;
                mid_d = prev_q;
            end else if (pop) begin
                sym_d = sym_mem[rd_next];
                mid_d = mid_mem[rd_next];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            prev_q  <= '0;
            sym_q   <= '0;
            mid_q   <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            level_q <= '0;
            ovf_q   <= 1'b0;
            drop_q  <= '0;
        end else begin
            if (x_valid) begin
                prev_q <= x_in;
            end
            sym_q   <= sym_d;
            mid_q   <= mid_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            level_q <= level_d;
            ovf_q   <= ovf_d;
            drop_q  <= drop_d;
        end
    end

    // The storage array needs no reset: pointers and level define its contents.
    always_ff @(posedge clk) begin
        if (!rst && !clr && push_ok) begin
            sym_mem[wr_q] <= x_in;
            mid_mem[wr_q] <= prev_q;
        end
    end

endmodule

// File: tb/tb_strobe_decimator.sv
module tb_strobe_decimator;

    localparam int DW    = 16;
    localparam int DEPTH = 4;
    localparam int CW    = 2;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic                 clk;
    logic                 rst;
    logic signed [DW-1:0] x_in;
    logic                 x_valid;
    logic                 underflow;
    logic                 clr;
    logic signed [DW-1:0] sym_out;
    logic signed [DW-1:0] mid_out;
    logic                 out_valid;
    logic                 out_ready;
    logic [LW-1:0]        level;
    logic                 overflow;
    logic [CW-1:0]        drop_cnt;

    strobe_decimator #(
        .DATA_WIDTH(DW),
        .DEPTH     (DEPTH),
        .CNT_WIDTH (CW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .x_in     (x_in),
        .x_valid  (x_valid),
        .underflow(underflow),
        .clr      (clr),
        .sym_out  (sym_out),
        .mid_out  (mid_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .level    (level),
        .overflow (overflow),
        .drop_cnt (drop_cnt)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard state ----------------
    logic [2*DW-1:0] exp_q[$];
    logic [DW-1:0]   m_prev;
    logic            m_ovf;
    int              m_drop;
    int              n_checks;
    int              n_fail;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver ----------------
    // Drives one cycle of inputs at the falling edge. The expected-pair queue
    // is updated for that cycle, and the task returns at the next falling edge.
    task automatic cycle(input logic xv, input logic uf, input logic [DW-1:0] x,
                         input logic rdy, input logic r, input logic c);
        logic [2*DW-1:0] e;
        x_valid   = xv;
        underflow = uf;
        x_in      = x;
        out_ready = rdy;
        rst       = r;
        clr       = c;
        if (r || c) begin
            exp_q.delete();
            m_prev = '0;
            m_ovf  = 1'b0;
            m_drop = 0;
        end else begin
            if (out_valid && rdy) begin
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_valid", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("pop_sym", 32'(sym_out), 32'(e[2*DW-1:DW]));
                    check("pop_mid", 32'(mid_out), 32'(e[DW-1:0]));
                end
            end
            if (xv && uf) begin
                if (exp_q.size() < DEPTH) begin
                    exp_q.push_back({x, m_prev});
                end else begin
                    m_ovf = 1'b1;
                    if (m_drop < (1 << CW) - 1) m_drop++;
                end
            end
            if (xv) m_prev = x;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_level"}, 32'(level), 32'(exp_q.size()));
        check({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
        check({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic          xv;
        logic          uf;
        logic [DW-1:0] x;
        logic          rdy;
        logic          ev;
        logic [DW-1:0] es;
        logic [DW-1:0] em;
        logic [LW-1:0] el;
    } vec_t;

    vec_t vecs[10];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        m_prev   = '0;
        m_ovf    = 1'b0;
        m_drop   = 0;
        x_valid = 0; underflow = 0; x_in = '0; out_ready = 0; rst = 1; clr = 0;

        //           xv uf   x  rdy  ev  sym mid lvl
        vecs[0] = '{1, 0, 10, 1,  0,  9,  0, 0};
        vecs[1] = '{1, 0, 20, 1,  0,  9,  0, 0};
        vecs[2] = '{1, 1, 30, 1,  1, 30, 20, 1};
        vecs[3] = '{1, 0, 40, 1,  0, 30, 20, 0};
        vecs[4] = '{1, 1, 50, 1,  1, 50, 40, 1};
        vecs[5] = '{0, 0,  0, 1,  0, 50, 40, 0};
        vecs[6] = '{1, 0,  5, 1,  0, 50, 40, 0};
        vecs[7] = '{0, 1, 99, 1,  0, 50, 40, 0};
        vecs[8] = '{1, 1,  7, 1,  1,  7,  5, 1};
        vecs[9] = '{0, 0,  0, 1,  0,  7,  5, 0};

        // Initial reset
        cycle(0, 0, 0, 0, 1, 0);
        cycle(0, 0, 0, 0, 1, 0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_sym", 32'(sym_out), 32'd0);
        check("rst_mid", 32'(mid_out), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_drop", 32'(drop_cnt), 32'd0);

        // Test 1: reset in the middle of a stream
        cycle(1, 1, 1, 0, 0, 0);
        cycle(1, 1, 2, 0, 0, 0);
        cycle(1, 1, 3, 0, 0, 0);
        check("t1_level_pre", 32'(level), 32'd3);
        check("t1_head_sym", 32'(sym_out), 32'd1);
        cycle(0, 0, 0, 0, 1, 0);
        check("t1_valid", 32'(out_valid), 32'd0);
        check("t1_level", 32'(level), 32'd0);
        check("t1_sym", 32'(sym_out), 32'd0);
        check("t1_mid", 32'(mid_out), 32'd0);
        check("t1_ovf", 32'(overflow), 32'd0);
        check("t1_drop", 32'(drop_cnt), 32'd0);
        cycle(1, 1, 9, 1, 0, 0);
        check("t1_first_sym", 32'(sym_out), 32'd9);
        check("t1_first_mid", 32'(mid_out), 32'd0);
        cycle(0, 0, 0, 1, 0, 0);
        check_model("t1_end");

        // Tests 2 and 3: decimation, gaps and ignored strobes
        for (int i = 0; i < 10; i++) begin
            cycle(vecs[i].xv, vecs[i].uf, vecs[i].x, vecs[i].rdy, 0, 0);
            check($sformatf("vec%0d_valid", i), 32'(out_valid), 32'(vecs[i].ev));
            check($sformatf("vec%0d_sym", i), 32'(sym_out), 32'(vecs[i].es));
            check($sformatf("vec%0d_mid", i), 32'(mid_out), 32'(vecs[i].em));
            check($sformatf("vec%0d_level", i), 32'(level), 32'(vecs[i].el));
            check($sformatf("vec%0d_drop", i), 32'(drop_cnt), 32'd0);
        end

        // Test 4: backpressure and overflow
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 6; k++) begin
            cycle(1, 1, DW'(k), 0, 0, 0);
            check($sformatf("t4_stall_sym%0d", k), 32'(sym_out), 32'd1);
            check($sformatf("t4_stall_mid%0d", k), 32'(mid_out), 32'd0);
            check($sformatf("t4_stall_valid%0d", k), 32'(out_valid), 32'd1);
        end
        check("t4_level", 32'(level), 32'd4);
        check("t4_ovf", 32'(overflow), 32'd1);
        check("t4_drop", 32'(drop_cnt), 32'd2);
        cycle(0, 0, 0, 0, 0, 0);
        check("t4_hold_sym", 32'(sym_out), 32'd1);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0, 0);
        check("t4_drained", 32'(level), 32'd0);
        check_model("t4_end");

        // Test 5: full FIFO with push and pop in the same cycle
        for (int k = 11; k <= 14; k++) cycle(1, 1, DW'(k), 0, 0, 0);
        check("t5_full", 32'(level), 32'd4);
        cycle(1, 1, 15, 1, 0, 0);
        check("t5_level", 32'(level), 32'd4);
        check("t5_drop", 32'(drop_cnt), 32'd2);
        check("t5_head_sym", 32'(sym_out), 32'd12);
        check("t5_head_mid", 32'(mid_out), 32'd11);
        for (int k = 0; k < 4; k++) cycle(0, 0, 0, 1, 0, 0);
        check_model("t5_end");

        // Test 6: drop counter saturation, then clr
        cycle(0, 0, 0, 0, 0, 1);
        for (int k = 1; k <= 9; k++) cycle(1, 1, DW'(20 + k), 0, 0, 0);
        check("t6_drop_sat", 32'(drop_cnt), 32'd3);
        check("t6_ovf", 32'(overflow), 32'd1);
        check_model("t6_sat");
        cycle(1, 1, 77, 1, 0, 1);
        check("t6_clr_level", 32'(level), 32'd0);
        check("t6_clr_valid", 32'(out_valid), 32'd0);
        check("t6_clr_ovf", 32'(overflow), 32'd0);
        check("t6_clr_drop", 32'(drop_cnt), 32'd0);
        check("t6_clr_sym", 32'(sym_out), 32'd0);
        cycle(1, 1, 42, 0, 0, 0);
        check("t6_next_sym", 32'(sym_out), 32'd42);
        check("t6_next_mid", 32'(mid_out), 32'd0);
        cycle(0, 0, 0, 1, 0, 0);
        check_model("t6_end");
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // Final report
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
